// File: rtl/ioctl_load_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// bwidow_pkg
// Shared definitions for the ioctl download sequencer: loader FSM states,
// ioctl download index constants and core model-select encodings.
// ----------------------------------------------------------------------------
package bwidow_pkg;

    typedef enum logic [1:0] {
        LD_HOLD,
        LD_RUN,
        LD_LOAD
    } ld_state_e;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    localparam logic [1:0] MOD_BWIDOW   = 2'd0;
    localparam logic [1:0] MOD_GRAVITAR = 2'd1;
    localparam logic [1:0] MOD_LUNARBAT = 2'd2;
    localparam logic [1:0] MOD_SPACDUEL = 2'd3;

endpackage

// File: rtl/ioctl_load_ctrl_if.sv
// ----------------------------------------------------------------------------
// ioctl_load_ctrl_if
// Bundles the hps_io ioctl download bus and the core ROM write port.
//   ioctl_download/wr/addr/dout/index : download stream from hps_io
//   rom_wr/rom_addr/rom_data          : registered ROM write port to the core
// Modports:
//   slave  - the loader (consumes ioctl, drives the ROM port)
//   master - the hps_io side (drives ioctl, observes the ROM port)
// ----------------------------------------------------------------------------
interface ioctl_load_ctrl_if #(
    parameter int unsigned ROM_AW = 16
) ();

    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;

    logic              rom_wr;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output rom_wr, rom_addr, rom_data
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  rom_wr, rom_addr, rom_data
    );

endinterface

// File: rtl/ioctl_load_ctrl_reset_stretch.sv
// ----------------------------------------------------------------------------
// reset_stretch
// Loadable down-counter used to extend core reset. Resets to Hold-1, reloads
// Hold-1 on load_i, decrements while en_i and nonzero, and never wraps.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   load_i  : reload Hold-1 (wins over en_i)
//   en_i    : decrement enable
//   done_o  : count is zero
// ----------------------------------------------------------------------------
module reset_stretch #(
    parameter int unsigned Hold = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CntW = (Hold > 2) ? $clog2(Hold) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(Hold - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = Reload;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= Reload;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ioctl_load_ctrl.sv
// ----------------------------------------------------------------------------
// ioctl_load_ctrl
// Download sequencer and core reset controller between hps_io and the arcade
// core. Routes ioctl writes by index: 0 -> ROM write port (only while loading),
// 1 -> model select, 254 -> DIP banks. Holds the core in reset during a ROM
// download and for RST_HOLD cycles afterwards or after sys_reset.
// All outputs are registered in the clk_25 domain.
// Ports:
//   clk_25       : system clock
//   RESET_L      : asynchronous active-low reset
//   sys_reset    : synchronous active-high reset request (level)
//   bus          : ioctl download bus in, ROM write port out (slave modport)
//   sw           : DIP banks, byte n at sw[8n+7:8n]
//   mod_id       : model select
//   core_reset_l : active-low core reset
//   rom_oob      : sticky, an index-0 byte fell outside the ROM range
//   rom_sum      : ROM byte checksum since the last download start
// Optional feature macro: LOADER_CHECKSUM_EN enables the rom_sum adder;
// otherwise rom_sum is tied to zero.
// ----------------------------------------------------------------------------
module ioctl_load_ctrl
    import bwidow_pkg::*;
#(
    parameter int unsigned ROM_AW   = 16,
    parameter int unsigned RST_HOLD = 1024
) (
    input  logic               clk_25,
    input  logic               RESET_L,
    input  logic               sys_reset,
    ioctl_load_ctrl_if.slave   bus,
    output logic [63:0]        sw,
    output logic [1:0]         mod_id,
    output logic               core_reset_l,
    output logic               rom_oob,
    output logic [15:0]        rom_sum
);

    ld_state_e         state_q, state_d;
    logic              cnt_load, cnt_en, cnt_done;

    logic              rom_wr_q, rom_wr_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        rom_data_q, rom_data_d;
    logic [63:0]       sw_q, sw_d;
    logic [1:0]        mod_id_q, mod_id_d;
    logic              core_rst_l_q;
    logic              rom_oob_q, rom_oob_d;

    logic              rom_dl_start;
    logic              load_entry;
    logic              rom_wr_hit;
    logic              in_range;
    logic              rom_accept;

    reset_stretch #(
        .Hold (RST_HOLD)
    ) u_reset_stretch (
        .clk_i  (clk_25),
        .rst_ni (RESET_L),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .done_o (cnt_done)
    );

    assign rom_dl_start = bus.ioctl_download && (bus.ioctl_index == IDX_ROM);

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            LD_HOLD: begin
                cnt_en = 1'b1;
                if (sys_reset) begin
                    cnt_load = 1'b1;
                end else if (cnt_done) begin
                    state_d = LD_RUN;
                end
            end
            LD_RUN: begin
                if (sys_reset) begin
                    state_d  = LD_HOLD;
                    cnt_load = 1'b1;
                end
            end
            LD_LOAD: begin
                // sys_reset is deliberately ignored while loading
                if (!bus.ioctl_download) begin
                    state_d  = LD_HOLD;
                    cnt_load = 1'b1;
                end
            end
            default: begin
                state_d  = LD_HOLD;
                cnt_load = 1'b1;
            end
        endcase
        if (rom_dl_start) begin
            state_d = LD_LOAD;
        end
    end

    assign load_entry = (state_q != LD_LOAD) && (state_d == LD_LOAD);

    // ROM bytes are only taken while already in LOAD; this still covers the
    // write that coincides with the download falling edge.
    assign rom_wr_hit = bus.ioctl_wr && (bus.ioctl_index == IDX_ROM) && (state_q == LD_LOAD);
    assign in_range   = ((bus.ioctl_addr >> ROM_AW) == 25'd0);
    assign rom_accept = rom_wr_hit && in_range;

    always_comb begin
        rom_wr_d   = rom_accept;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        if (rom_accept) begin
            rom_addr_d = bus.ioctl_addr[ROM_AW-1:0];
            rom_data_d = bus.ioctl_dout;
        end

        rom_oob_d = rom_oob_q | (rom_wr_hit && !in_range);
        if (load_entry) begin
            rom_oob_d = 1'b0;
        end

        mod_id_d = mod_id_q;
        if (bus.ioctl_wr && (bus.ioctl_index == IDX_MOD) &&
            (bus.ioctl_dout <= {6'd0, MOD_SPACDUEL})) begin
            mod_id_d = bus.ioctl_dout[1:0];
        end

        sw_d = sw_q;
        if (bus.ioctl_wr && (bus.ioctl_index == IDX_DIP) && (bus.ioctl_addr[24:3] == 22'd0)) begin
            sw_d[{bus.ioctl_addr[2:0], 3'b000} +: 8] = bus.ioctl_dout;
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q      <= LD_HOLD;
            rom_wr_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= 8'h00;
            sw_q         <= 64'd0;
            mod_id_q     <= MOD_BWIDOW;
            core_rst_l_q <= 1'b0;
            rom_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_wr_q     <= rom_wr_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            sw_q         <= sw_d;
            mod_id_q     <= mod_id_d;
            // Follows the registered state, so release lands one edge after RUN entry
            core_rst_l_q <= (state_q == LD_RUN);
            rom_oob_q    <= rom_oob_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] rom_sum_q, rom_sum_d;

    always_comb begin
        rom_sum_d = rom_sum_q;
        if (load_entry) begin
            rom_sum_d = 16'h0000;
        end else if (rom_accept) begin
            rom_sum_d = rom_sum_q + {8'h00, bus.ioctl_dout};
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            rom_sum_q <= 16'h0000;
        end else begin
            rom_sum_q <= rom_sum_d;
        end
    end

    assign rom_sum = rom_sum_q;
`else
    assign rom_sum = 16'h0000;
`endif

    assign bus.rom_wr   = rom_wr_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_data = rom_data_q;
    assign sw           = sw_q;
    assign mod_id       = mod_id_q;
    assign core_reset_l = core_rst_l_q;
    assign rom_oob      = rom_oob_q;

endmodule

// File: tb/tb_ioctl_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ioctl_load_ctrl
// Directed bench for ioctl_load_ctrl with ROM_AW=16, RST_HOLD=16. Writes are
// applied from vector tables; reset-stretch timing and async reset are
// hand-sequenced. Honours LOADER_CHECKSUM_EN for rom_sum expectations.
// ----------------------------------------------------------------------------
module tb_ioctl_load_ctrl;

    localparam int unsigned ROM_AW   = 16;
    localparam int unsigned RST_HOLD = 16;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CkEn = 1'b1;
`else
    localparam bit CkEn = 1'b0;
`endif

    typedef struct {
        logic        dl;
        logic        sysr;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic        wr;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic [63:0] e_sw;
        logic [1:0]  e_mod;
        logic        e_core;
        logic        e_oob;
        logic [15:0] e_sum;
    } vec_t;

    logic        clk_25 = 1'b0;
    logic        RESET_L;
    logic        sys_reset;
    logic [63:0] sw;
    logic [1:0]  mod_id;
    logic        core_reset_l;
    logic        rom_oob;
    logic [15:0] rom_sum;

    int n_cmp = 0;
    int n_bad = 0;

    ioctl_load_ctrl_if #(.ROM_AW(ROM_AW)) bus ();

    ioctl_load_ctrl #(
        .ROM_AW   (ROM_AW),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk_25       (clk_25),
        .RESET_L      (RESET_L),
        .sys_reset    (sys_reset),
        .bus          (bus),
        .sw           (sw),
        .mod_id       (mod_id),
        .core_reset_l (core_reset_l),
        .rom_oob      (rom_oob),
        .rom_sum      (rom_sum)
    );

    always #5 clk_25 = ~clk_25;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample point: 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    function automatic vec_t mkv(input logic dl, input logic sysr, input logic [7:0] idx,
                                 input logic [24:0] addr, input logic [7:0] dout,
                                 input logic wr, input logic e_wr, input logic [15:0] e_addr,
                                 input logic [7:0] e_data, input logic [63:0] e_sw,
                                 input logic [1:0] e_mod, input logic e_core,
                                 input logic e_oob, input logic [15:0] e_sum);
        vec_t v;
        v.dl = dl; v.sysr = sysr; v.idx = idx; v.addr = addr; v.dout = dout; v.wr = wr;
        v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data; v.e_sw = e_sw;
        v.e_mod = e_mod; v.e_core = e_core; v.e_oob = e_oob; v.e_sum = e_sum;
        return v;
    endfunction

    task automatic run_vecs(input string tag, input vec_t vs[$]);
        foreach (vs[i]) begin
            bus.ioctl_download = vs[i].dl;
            sys_reset          = vs[i].sysr;
            bus.ioctl_index    = vs[i].idx;
            bus.ioctl_addr     = vs[i].addr;
            bus.ioctl_dout     = vs[i].dout;
            bus.ioctl_wr       = vs[i].wr;
            tick();
            chk($sformatf("%s[%0d].rom_wr", tag, i), 64'(bus.rom_wr), 64'(vs[i].e_wr));
            chk($sformatf("%s[%0d].rom_addr", tag, i), 64'(bus.rom_addr), 64'(vs[i].e_addr));
            chk($sformatf("%s[%0d].rom_data", tag, i), 64'(bus.rom_data), 64'(vs[i].e_data));
            chk($sformatf("%s[%0d].sw", tag, i), sw, vs[i].e_sw);
            chk($sformatf("%s[%0d].mod_id", tag, i), 64'(mod_id), 64'(vs[i].e_mod));
            chk($sformatf("%s[%0d].core_reset_l", tag, i), 64'(core_reset_l), 64'(vs[i].e_core));
            chk($sformatf("%s[%0d].rom_oob", tag, i), 64'(rom_oob), 64'(vs[i].e_oob));
            chk($sformatf("%s[%0d].rom_sum", tag, i), 64'(rom_sum), 64'(vs[i].e_sum));
        end
        bus.ioctl_wr = 1'b0;
        sys_reset    = 1'b0;
    endtask

    // Expects core_reset_l low after edges 1..RST_HOLD and high after RST_HOLD+1.
    task automatic chk_release(input string tag);
        for (int k = 1; k <= int'(RST_HOLD); k++) begin
            tick();
            chk($sformatf("%s.core_low_e%0d", tag, k), 64'(core_reset_l), 64'd0);
        end
        tick();
        chk($sformatf("%s.core_high", tag), 64'(core_reset_l), 64'd1);
    endtask

    localparam logic [63:0] Sw1 = 64'h0000_0000_005A_0000;
    localparam logic [63:0] Sw2 = 64'h0000_0000_005A_0012;
    localparam logic [63:0] Sw3 = 64'hC300_0000_005A_0012;

    initial begin
        vec_t va[$];
        vec_t vb[$];

        RESET_L            = 1'b0;
        sys_reset          = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        bus.ioctl_index    = 8'd0;

        // Reset values
        tick();
        tick();
        chk("rst.rom_wr", 64'(bus.rom_wr), 64'd0);
        chk("rst.rom_addr", 64'(bus.rom_addr), 64'd0);
        chk("rst.rom_data", 64'(bus.rom_data), 64'd0);
        chk("rst.sw", sw, 64'd0);
        chk("rst.mod_id", 64'(mod_id), 64'd0);
        chk("rst.core_reset_l", 64'(core_reset_l), 64'd0);
        chk("rst.rom_oob", 64'(rom_oob), 64'd0);
        chk("rst.rom_sum", 64'(rom_sum), 64'd0);
        RESET_L = 1'b1;
        chk_release("por");

        // DIP / model select / stray writes while running
        va.push_back(mkv(0, 0, 8'd254, 25'd2, 8'h5A, 1, 0, 16'h0, 8'h0, Sw1, 2'd0, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd254, 25'd8, 8'hFF, 1, 0, 16'h0, 8'h0, Sw1, 2'd0, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd254, 25'd0, 8'h12, 1, 0, 16'h0, 8'h0, Sw2, 2'd0, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd254, 25'd7, 8'hC3, 1, 0, 16'h0, 8'h0, Sw3, 2'd0, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd1,   25'd0, 8'h02, 1, 0, 16'h0, 8'h0, Sw3, 2'd2, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd1,   25'd0, 8'h07, 1, 0, 16'h0, 8'h0, Sw3, 2'd2, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd0,   25'd5, 8'h99, 1, 0, 16'h0, 8'h0, Sw3, 2'd2, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd3,   25'd0, 8'h01, 1, 0, 16'h0, 8'h0, Sw3, 2'd2, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd1,   25'd0, 8'h03, 0, 0, 16'h0, 8'h0, Sw3, 2'd2, 1, 0, 16'h0));
        va.push_back(mkv(0, 0, 8'd1,   25'd0, 8'h01, 1, 0, 16'h0, 8'h0, Sw3, 2'd1, 1, 0, 16'h0));
        run_vecs("run", va);

        // Start ROM download; core reset asserts one edge later
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        tick();
        chk("dl_start.rom_oob", 64'(rom_oob), 64'd0);

        vb.push_back(mkv(1, 0, 8'd0, 25'd0, 8'h11, 1, 1, 16'h0, 8'h11, Sw3, 2'd1, 0, 0,
                         CkEn ? 16'h0011 : 16'h0));
        vb.push_back(mkv(1, 0, 8'd0, 25'd1, 8'h22, 1, 1, 16'h1, 8'h22, Sw3, 2'd1, 0, 0,
                         CkEn ? 16'h0033 : 16'h0));
        vb.push_back(mkv(1, 0, 8'd0, 25'd2, 8'h33, 1, 1, 16'h2, 8'h33, Sw3, 2'd1, 0, 0,
                         CkEn ? 16'h0066 : 16'h0));
        vb.push_back(mkv(1, 0, 8'd0, 25'd3, 8'h44, 1, 1, 16'h3, 8'h44, Sw3, 2'd1, 0, 0,
                         CkEn ? 16'h00AA : 16'h0));
        vb.push_back(mkv(1, 0, 8'd0, 25'h10000, 8'h55, 1, 0, 16'h3, 8'h44, Sw3, 2'd1, 0, 1,
                         CkEn ? 16'h00AA : 16'h0));
        vb.push_back(mkv(1, 0, 8'd1, 25'd0, 8'h03, 1, 0, 16'h3, 8'h44, Sw3, 2'd3, 0, 1,
                         CkEn ? 16'h00AA : 16'h0));
        vb.push_back(mkv(1, 1, 8'd0, 25'd0, 8'h00, 0, 0, 16'h3, 8'h44, Sw3, 2'd3, 0, 1,
                         CkEn ? 16'h00AA : 16'h0));
        vb.push_back(mkv(1, 0, 8'd0, 25'd0, 8'h00, 0, 0, 16'h3, 8'h44, Sw3, 2'd3, 0, 1,
                         CkEn ? 16'h00AA : 16'h0));
        run_vecs("load", vb);

        // Download falls with a write in the same cycle: write still lands
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_addr     = 25'd4;
        bus.ioctl_dout     = 8'h10;
        bus.ioctl_wr       = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        chk("fall.rom_wr", 64'(bus.rom_wr), 64'd1);
        chk("fall.rom_addr", 64'(bus.rom_addr), 64'd4);
        chk("fall.rom_data", 64'(bus.rom_data), 64'h10);
        chk("fall.rom_sum", 64'(rom_sum), CkEn ? 64'h00BA : 64'h0);
        chk("fall.core_reset_l", 64'(core_reset_l), 64'd0);
        chk_release("dl_end");
        chk("post_dl.rom_wr", 64'(bus.rom_wr), 64'd0);
        chk("post_dl.rom_oob", 64'(rom_oob), 64'd1);
        chk("post_dl.rom_sum", 64'(rom_sum), CkEn ? 64'h00BA : 64'h0);

        // New download clears oob and sum, then an async reset aborts it
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = 8'd0;
        tick();
        chk("dl2.rom_oob", 64'(rom_oob), 64'd0);
        chk("dl2.rom_sum", 64'(rom_sum), 64'd0);
        bus.ioctl_addr = 25'd7;
        bus.ioctl_dout = 8'h77;
        bus.ioctl_wr   = 1'b1;
        #2;
        RESET_L            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        #1;
        chk("abort.rom_wr", 64'(bus.rom_wr), 64'd0);
        chk("abort.core_reset_l", 64'(core_reset_l), 64'd0);
        chk("abort.rom_addr", 64'(bus.rom_addr), 64'd0);
        chk("abort.sw", sw, 64'd0);
        tick();
        tick();
        RESET_L = 1'b1;
        chk_release("abort");
        chk("abort_end.rom_wr", 64'(bus.rom_wr), 64'd0);
        chk("abort_end.rom_oob", 64'(rom_oob), 64'd0);

        // sys_reset in RUN, then a second pulse mid-HOLD restarts the count
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        chk("sysr.core_same_edge", 64'(core_reset_l), 64'd1);
        tick();
        chk("sysr.core_next_edge", 64'(core_reset_l), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("sysr.hold%0d", k), 64'(core_reset_l), 64'd0);
        end
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        chk("sysr2.core", 64'(core_reset_l), 64'd0);
        chk_release("sysr2");
        chk("final.sw", sw, 64'd0);
        chk("final.mod_id", 64'(mod_id), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
